// File: rtl/tdm_pkg.sv
// Shared types and constants for the four-channel TDM demultiplexer.
package tdm_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] slot_t;

    typedef enum logic {
        HUNT,
        LOCK
    } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Two-bit slot counter for the TDM demultiplexer: wraps mod 4, can be forced to slot 1.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  inc,
    input  logic  load1,
    output slot_t slot,
    output logic  last
);

    // load1 wins over inc: a new frame's ch0 word always leaves the counter at slot 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else if (load1) begin
            slot <= 2'd1;
        end else if (inc) begin
            slot <= slot + 2'd1;
        end
    end

    assign last = (slot == 2'd3);

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: HUNT/LOCK framing FSM, per-channel hold and output registers.
// Optional even-parity checking on din is enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic             din_par,
    output logic             par_err,
`endif
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             out_valid,
    output logic             locked,
    output logic             sync_err
);

    state_t           state;
    state_t           state_next;
    slot_t            slot;
    logic             last;
    logic             ctr_inc;
    logic             ctr_load;
    logic             start_frame;
    logic             complete;
    logic             misalign;
    logic             publish;
    slot_t            write_slot;
    logic             write_en;
    logic [WIDTH-1:0] hold [NUM_CH-1];

`ifdef TDM_DEMUX_PARITY_EN
    logic             bad_now;
    logic             frame_bad;
    logic             frame_bad_next;
`endif

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctr_inc),
        .load1 (ctr_load),
        .slot  (slot),
        .last  (last)
    );

    // Framing decisions; slot 3 has no hold register because din goes straight to y3
    always_comb begin
        state_next  = state;
        ctr_inc     = 1'b0;
        ctr_load    = 1'b0;
        start_frame = 1'b0;
        complete    = 1'b0;
        misalign    = 1'b0;
        case (state)
            HUNT: begin
                if (din_valid && frame_sync) begin
                    start_frame = 1'b1;
                    ctr_load    = 1'b1;
                    state_next  = LOCK;
                end
            end
            LOCK: begin
                if (din_valid) begin
                    if (frame_sync && (slot != 2'd0)) begin
                        misalign    = 1'b1;
                        start_frame = 1'b1;
                        ctr_load    = 1'b1;
                    end else begin
                        ctr_inc  = 1'b1;
                        complete = last;
                    end
                end
            end
            default: state_next = HUNT;
        endcase
        write_en   = start_frame | ctr_inc;
        write_slot = start_frame ? 2'd0 : slot;
    end

`ifdef TDM_DEMUX_PARITY_EN
    // A bad word poisons the rest of its frame; a fresh ch0 word starts a clean frame
    always_comb begin
        bad_now        = (state == LOCK) && din_valid && (din_par != ^din);
        frame_bad_next = frame_bad;
        if (start_frame || complete) begin
            frame_bad_next = 1'b0;
        end
        if (bad_now && !complete) begin
            frame_bad_next = 1'b1;
        end
        publish = complete && !frame_bad && !bad_now;
    end
`else
    assign publish = complete;
`endif

    assign locked = (state == LOCK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            hold[0]   <= '0;
            hold[1]   <= '0;
            hold[2]   <= '0;
            y0        <= '0;
            y1        <= '0;
            y2        <= '0;
            y3        <= '0;
        end else begin
            state     <= state_next;
            out_valid <= publish;
            sync_err  <= misalign;
            if (write_en) begin
                case (write_slot)
                    2'd0:    hold[0] <= din;
                    2'd1:    hold[1] <= din;
                    2'd2:    hold[2] <= din;
                    default: ;
                endcase
            end
            if (publish) begin
                y0 <= hold[0];
                y1 <= hold[1];
                y2 <= hold[2];
                y3 <= din;
            end
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err   <= 1'b0;
            frame_bad <= 1'b0;
        end else begin
            par_err   <= bad_now;
            frame_bad <= frame_bad_next;
        end
    end
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed frames plus randomized traffic against a frame-queue model.
module tb_tdm_demux4;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         frame_sync = 1'b0;
    logic [W-1:0] y0, y1, y2, y3;
    logic         out_valid, locked, sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic         din_par = 1'b0;
    logic         par_err;
`endif

    always #5 clk = ~clk;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
`ifdef TDM_DEMUX_PARITY_EN
        .din_par    (din_par),
        .par_err    (par_err),
`endif
        .y0         (y0),
        .y1         (y1),
        .y2         (y2),
        .y3         (y3),
        .out_valid  (out_valid),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: words of the frame in progress, last published frame, pulse expectations
    logic [W-1:0] frame_q[$];
    logic [W-1:0] exp_y [4];
    logic         exp_ov, exp_se, exp_pe;
    bit           m_locked, m_bad;

    task automatic model_reset();
        frame_q.delete();
        for (int i = 0; i < 4; i++) exp_y[i] = '0;
        exp_ov = 1'b0;
        exp_se = 1'b0;
        exp_pe = 1'b0;
        m_locked = 1'b0;
        m_bad = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        din_valid = 1'b0;
        frame_sync = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock of stimulus; returns 1ns after the edge with the model updated
    task automatic step(input bit v, input bit s, input logic [W-1:0] d, input bit bad);
        @(negedge clk);
        din = d;
        din_valid = v;
        frame_sync = s;
`ifdef TDM_DEMUX_PARITY_EN
        din_par = (^d) ^ bad;
`endif
        exp_ov = 1'b0;
        exp_se = 1'b0;
        exp_pe = 1'b0;
        if (v) begin
            if (m_locked && bad) exp_pe = 1'b1;
            if (!m_locked) begin
                if (s) begin
                    m_locked = 1'b1;
                    frame_q = {d};
                    m_bad = 1'b0;
                end
            end else if (s) begin
                if (frame_q.size() != 0) exp_se = 1'b1;
                frame_q = {d};
                m_bad = exp_pe;
            end else begin
                frame_q.push_back(d);
                if (exp_pe) m_bad = 1'b1;
            end
            if (frame_q.size() == 4) begin
                if (!m_bad) begin
                    for (int i = 0; i < 4; i++) exp_y[i] = frame_q[i];
                    exp_ov = 1'b1;
                end
                frame_q.delete();
                m_bad = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({y0, y1, y2, y3, out_valid, sync_err, locked} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_values: got %h expected 0", {y0, y1, y2, y3, out_valid, sync_err, locked});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 8'h5A, 1'b0);
        checks++;
        if (locked !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_hunt: locked=%b out_valid=%b expected 0 0", locked, out_valid);
        end
    endtask

    task automatic test_basic_frame();
        logic [W-1:0] words [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        int ov_count = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i == 0), words[i], 1'b0);
            if (out_valid === 1'b1) ov_count++;
            checks++;
            if ({y0, y1, y2, y3, out_valid, sync_err, locked} !==
                {exp_y[0], exp_y[1], exp_y[2], exp_y[3], exp_ov, exp_se, m_locked}) begin
                failures++;
                $display("[TB] FAIL basic_step%0d: got %h expected %h", i,
                         {y0, y1, y2, y3, out_valid, sync_err, locked},
                         {exp_y[0], exp_y[1], exp_y[2], exp_y[3], exp_ov, exp_se, m_locked});
            end
        end
        checks++;
        if ({y0, y1, y2, y3} !== 32'hA1B2C3D4 || ov_count != 1 || locked !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_frame: y=%h ov_count=%0d locked=%b expected a1b2c3d4 1 1",
                     {y0, y1, y2, y3}, ov_count, locked);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || {y0, y1, y2, y3} !== 32'hA1B2C3D4) begin
            failures++;
            $display("[TB] FAIL basic_hold: out_valid=%b y=%h expected 0 a1b2c3d4", out_valid, {y0, y1, y2, y3});
        end
    endtask

    task automatic test_hunt_discard();
        logic [W-1:0] words [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, (i == 2), words[i], 1'b0);
            checks++;
            if ({y0, y1, y2, y3, out_valid, sync_err, locked} !==
                {exp_y[0], exp_y[1], exp_y[2], exp_y[3], exp_ov, exp_se, m_locked}) begin
                failures++;
                $display("[TB] FAIL hunt_step%0d: got %h expected %h", i,
                         {y0, y1, y2, y3, out_valid, sync_err, locked},
                         {exp_y[0], exp_y[1], exp_y[2], exp_y[3], exp_ov, exp_se, m_locked});
            end
        end
        checks++;
        if ({y0, y1, y2, y3} !== 32'h33445566) begin
            failures++;
            $display("[TB] FAIL hunt_discard: y=%h expected 33445566", {y0, y1, y2, y3});
        end
    endtask

    task automatic test_gaps();
        logic [W-1:0] words [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        int ov_count = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i == 0), words[i], 1'b0);
            if (out_valid === 1'b1) ov_count++;
            checks++;
            if (out_valid !== (i == 3)) begin
                failures++;
                $display("[TB] FAIL gaps_word%0d: out_valid=%b expected %b", i, out_valid, (i == 3));
            end
            if (i != 3) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, (g == 1), 8'hEE, 1'b0);
                    if (out_valid === 1'b1) ov_count++;
                end
            end
        end
        checks++;
        if ({y0, y1, y2, y3} !== 32'h01020304 || ov_count != 1 || sync_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL gaps_frame: y=%h ov_count=%0d expected 01020304 1", {y0, y1, y2, y3}, ov_count);
        end
    endtask

    task automatic test_misaligned();
        logic [W-1:0] words [6] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        bit           syncs [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int se_count = 0;
        int ov_count = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, syncs[i], words[i], 1'b0);
            if (sync_err === 1'b1) se_count++;
            if (out_valid === 1'b1) ov_count++;
            checks++;
            if ({y0, y1, y2, y3, out_valid, sync_err, locked} !==
                {exp_y[0], exp_y[1], exp_y[2], exp_y[3], exp_ov, exp_se, m_locked}) begin
                failures++;
                $display("[TB] FAIL misalign_step%0d: got %h expected %h", i,
                         {y0, y1, y2, y3, out_valid, sync_err, locked},
                         {exp_y[0], exp_y[1], exp_y[2], exp_y[3], exp_ov, exp_se, m_locked});
            end
        end
        checks++;
        if ({y0, y1, y2, y3} !== 32'h30405060 || se_count != 1 || ov_count != 1) begin
            failures++;
            $display("[TB] FAIL misalign_frame: y=%h sync_err=%0d out_valid=%0d expected 30405060 1 1",
                     {y0, y1, y2, y3}, se_count, ov_count);
        end
    endtask

    task automatic test_back_to_back();
        int ov_count = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, (i % 4 == 0), W'(8'h80 + i), 1'b0);
            if (out_valid === 1'b1) ov_count++;
            checks++;
            if (out_valid !== (i % 4 == 3) ||
                {y0, y1, y2, y3} !== {exp_y[0], exp_y[1], exp_y[2], exp_y[3]}) begin
                failures++;
                $display("[TB] FAIL b2b_step%0d: out_valid=%b y=%h expected %b %h", i, out_valid,
                         {y0, y1, y2, y3}, (i % 4 == 3), {exp_y[0], exp_y[1], exp_y[2], exp_y[3]});
            end
        end
        checks++;
        if (ov_count != 3 || {y0, y1, y2, y3} !== 32'h88898A8B) begin
            failures++;
            $display("[TB] FAIL b2b_total: ov_count=%0d y=%h expected 3 88898a8b", ov_count, {y0, y1, y2, y3});
        end
    endtask

    task automatic test_reset_mid_frame();
        int ov_count = 0;
        do_reset();
        step(1'b1, 1'b1, 8'h0A, 1'b0);
        step(1'b1, 1'b0, 8'h0B, 1'b0);
        #2;
        din_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({y0, y1, y2, y3, out_valid, sync_err, locked} !== '0) begin
            failures++;
            $display("[TB] FAIL midreset_clear: got %h expected 0", {y0, y1, y2, y3, out_valid, sync_err, locked});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 8'h0C, 1'b0);
        step(1'b1, 1'b0, 8'h0D, 1'b0);
        step(1'b1, 1'b0, 8'h0E, 1'b0);
        if (out_valid === 1'b1) ov_count++;
        checks++;
        if (locked !== 1'b0 || ov_count != 0 || {y0, y1, y2, y3} !== '0) begin
            failures++;
            $display("[TB] FAIL midreset_hunt: locked=%b y=%h expected 0 0", locked, {y0, y1, y2, y3});
        end
    endtask

    task automatic test_random();
        bit v, s, bad;
        logic [W-1:0] d;
        int errs = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 5) == 0);
            d = W'($urandom);
            bad = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            bad = ($urandom_range(0, 9) == 0);
`endif
            step(v, s, d, bad);
            checks++;
            if ({y0, y1, y2, y3, out_valid, sync_err, locked} !==
                {exp_y[0], exp_y[1], exp_y[2], exp_y[3], exp_ov, exp_se, m_locked}) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("[TB] FAIL random_step%0d: got %h expected %h", i,
                             {y0, y1, y2, y3, out_valid, sync_err, locked},
                             {exp_y[0], exp_y[1], exp_y[2], exp_y[3], exp_ov, exp_se, m_locked});
            end
`ifdef TDM_DEMUX_PARITY_EN
            checks++;
            if (par_err !== exp_pe) begin
                failures++;
                $display("[TB] FAIL random_par%0d: par_err=%b expected %b", i, par_err, exp_pe);
            end
`endif
        end
    endtask

`ifdef TDM_DEMUX_PARITY_EN
    task automatic test_parity();
        int ov_count = 0;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, (i == 0), W'(8'h01 + i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i == 0), W'(8'h11 + i), (i == 2));
            if (out_valid === 1'b1) ov_count++;
            checks++;
            if (par_err !== (i == 2)) begin
                failures++;
                $display("[TB] FAIL parity_pulse%0d: par_err=%b expected %b", i, par_err, (i == 2));
            end
        end
        checks++;
        if ({y0, y1, y2, y3} !== 32'h01020304 || ov_count != 0) begin
            failures++;
            $display("[TB] FAIL parity_suppress: y=%h ov_count=%0d expected 01020304 0", {y0, y1, y2, y3}, ov_count);
        end
        for (int i = 0; i < 4; i++) step(1'b1, (i == 0), W'(8'h21 + i), 1'b0);
        checks++;
        if ({y0, y1, y2, y3} !== 32'h21222324 || out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL parity_recover: y=%h out_valid=%b expected 21222324 1", {y0, y1, y2, y3}, out_valid);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_basic_frame();
        test_hunt_discard();
        test_gaps();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef TDM_DEMUX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: the receive-side counterpart of the gate-level 4:1 mux. A word stream arrives on one input, one word per slot, with channel 0 marked by a frame-sync strobe. The block tracks the slot with a 2-bit counter (s1,s0) and collects words into per-channel holding registers. When a frame completes, it presents all four channels simultaneously. It sits between a serial/TDM link front end and four parallel consumers.

## Interface
Parameters:
- WIDTH, 8, data word width per channel.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  incoming TDM word.
- din_valid  input  1  din carries a word this cycle.
- frame_sync  input  1  qualified by din_valid; marks the word as channel 0.
- y0, y1, y2, y3  output  WIDTH each  reconstructed channel words, held between frames.
- out_valid  output  1  one-cycle pulse when y0..y3 update.
- locked  output  1  high while the block is aligned to the frame.
- sync_err  output  1  one-cycle pulse on misaligned frame_sync.

## Operation
- State machine: HUNT and LOCK. Reset enters HUNT.
- **HUNT**
  - Words without frame_sync are discarded.
  - A word with din_valid=1 and frame_sync=1 is stored as ch0, sets slot=1, and moves to LOCK.
- **LOCK**
  - Each word with din_valid=1 is stored into hold[slot], then slot increments mod 4.
  - When the word for slot 3 is stored, hold0..2 and din are copied to y0..y3 on the same edge, and out_valid pulses.
  - frame_sync with din_valid at slot 0 is normal operation.
  - frame_sync with din_valid at slot≠0:
    - sync_err pulses and the partial frame is discarded (no out_valid).
    - The word is stored as ch0, slot=1, and the block stays in LOCK (realign).
- din_valid=0: slot and hold registers are unchanged. Gaps of any length are allowed.
- frame_sync with din_valid=0 is ignored in both states.
- locked is 1 in LOCK and 0 in HUNT.
- y0..y3 are never partially updated; they change only with out_valid.

## Timing
- Reset values:
  - y0..y3 = 0, out_valid = 0, locked = 0, sync_err = 0.
  - slot = 0, state = HUNT, hold registers = 0.
- Latency: out_valid and the new y0..y3 appear on the edge that accepts the slot-3 word. They are visible the cycle after din_valid of that word is sampled.
- Throughput: one word per cycle sustained, i.e. one frame every 4 valid cycles. Back-to-back frames produce out_valid every 4th cycle.
- sync_err is registered and asserted the cycle after the offending word is sampled. It is never simultaneous with out_valid for the same word.
- locked rises the cycle after the first qualified frame_sync is sampled in HUNT.
- Reset asserted mid-frame clears everything immediately (asynchronous). The first cycle after deassertion is in HUNT.

## Configuration
- Macro `TDM_DEMUX_PARITY_EN`.
- **Defined:**
  - Adds input din_par (1), which is the even parity of din.
  - Adds output par_err (1, reset 0).
  - A valid word with bad parity in LOCK pulses par_err for one cycle.
  - The current frame is marked bad, and its completion suppresses out_valid and the y update.
  - The slot counter still advances.
  - In HUNT, parity errors are ignored.
- **Undefined:** no din_par or par_err ports, and no parity logic.

## Structure
- Shared package tdm_pkg:
  - NUM_CH = 4.
  - typedef slot_t as a 2-bit slot index.
  - enum state_t {HUNT, LOCK}.
- Sub-module tdm_slot_ctr: 2-bit wrap counter with inc and load-to-1 inputs, exposing slot and last = (slot==3).
- The top level holds the FSM, hold and output registers, and error logic.

## Test plan
- **Basic frame:** reset, then valid words A1(sync), B2, C3, D4 on consecutive cycles → y0..y3 = A1, B2, C3, D4, one out_valid pulse, locked=1.
- **HUNT discard:** words 11, 22 without sync, then 33(sync), 44, 55, 66 → y = 33, 44, 55, 66. Words 11 and 22 never appear.
- **Gaps:** frame 01(sync), 02, 03, 04 with din_valid low for 3 cycles between each word → same y values. out_valid occurs only after the 04 word.
- **Misaligned sync:** frame 10(sync), 20, then 30(sync), 40, 50, 60 → sync_err pulses once, with no out_valid for the partial frame. Then y = 30, 40, 50, 60.
- **Reset mid-frame:** after 0A(sync), 0B, assert rst → all outputs 0 and locked=0 immediately. After release, 0C, 0D, 0E are ignored until a sync arrives.
- **Parity (macro defined):** frame with a bad-parity word on slot 2 → par_err pulses, and y retains the previous frame. The next good frame updates y normally.
